// File: rtl/konami_sequencer_if.sv
// Command/status bundle between a Konami-code sequencer and whoever drives it.
// The master issues commands; the slave (the sequencer) drives the d-pad lines and status.
interface konami_sequencer_if;
  logic       start;
  logic       abort;
  logic       corrupt;
  logic [2:0] bad_step;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, corrupt, bad_step,
    input  up, down, left, right, busy, done
  );

  modport slave (
    input  start, abort, corrupt, bad_step,
    output up, down, left, right, busy, done
  );
endinterface

// File: rtl/konami_sequencer.sv
// Plays UP UP DOWN DOWN LEFT RIGHT LEFT RIGHT as timed press/release pulses on
// four registered d-pad lines, with an optional single-step corruption.
module konami_sequencer #(
  parameter int unsigned PRESS_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset_,
  konami_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [15:0] PRESS_LOAD = 16'(PRESS_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);
  localparam logic [2:0]  LAST_STEP  = 3'd7;

  state_t     state;
  logic [2:0] index;
  logic [15:0] timer;
  logic       corrupt_q;
  logic [2:0] bad_step_q;
  logic [3:0] lines;      // {up, down, left, right}
  logic       busy_q;
  logic       done_q;

  function automatic dir_t golden_dir(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: golden_dir = DIR_UP;
      3'd2, 3'd3: golden_dir = DIR_DOWN;
      3'd4, 3'd6: golden_dir = DIR_LEFT;
      default:    golden_dir = DIR_RIGHT;
    endcase
  endfunction

  // The substitute is always a rotation, so a corrupted step is never the golden one.
  function automatic dir_t substitute(input dir_t d);
    case (d)
      DIR_UP:   substitute = DIR_DOWN;
      DIR_DOWN: substitute = DIR_LEFT;
      DIR_LEFT: substitute = DIR_RIGHT;
      default:  substitute = DIR_UP;
    endcase
  endfunction

  function automatic logic [3:0] step_lines(input logic [2:0] i,
                                            input logic       cor,
                                            input logic [2:0] bs);
    dir_t d;
    d = golden_dir(i);
    if (cor && (i == bs)) d = substitute(d);
    case (d)
      DIR_UP:   step_lines = 4'b1000;
      DIR_DOWN: step_lines = 4'b0100;
      DIR_LEFT: step_lines = 4'b0010;
      default:  step_lines = 4'b0001;
    endcase
  endfunction

  // Outputs are computed from the next state at the same edge, so the first
  // press appears the cycle after start is sampled with no extra pipeline stage.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      index      <= '0;
      timer      <= '0;
      corrupt_q  <= 1'b0;
      bad_step_q <= '0;
      lines      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all updates see pre-edge values;
      // a blocking = would let later statements read the freshly written state.
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            corrupt_q  <= bus.corrupt;
            bad_step_q <= bus.bad_step;
            index      <= '0;
            timer      <= PRESS_LOAD;
            lines      <= step_lines(3'd0, bus.corrupt, bus.bad_step);
            busy_q     <= 1'b1;
            state      <= PRESS;
          end
        end

        PRESS: begin
          if (bus.abort) begin
            state  <= IDLE;
            index  <= '0;
            timer  <= '0;
            lines  <= '0;
            busy_q <= 1'b0;
          end else if (timer == '0) begin
            timer <= GAP_LOAD;
            lines <= '0;
            state <= GAP;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        GAP: begin
          if (bus.abort) begin
            state  <= IDLE;
            index  <= '0;
            timer  <= '0;
            lines  <= '0;
            busy_q <= 1'b0;
          end else if (timer == '0) begin
            if (index == LAST_STEP) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              index <= index + 3'd1;
              timer <= PRESS_LOAD;
              lines <= step_lines(index + 3'd1, corrupt_q, bad_step_q);
              state <= PRESS;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          lines  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.up    = lines[3];
  assign bus.down  = lines[2];
  assign bus.left  = lines[1];
  assign bus.right = lines[0];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  a_onehot_lines: assert property (@(posedge clk) disable iff (!reset_)
    $onehot0(lines));
  a_lines_only_in_press: assert property (@(posedge clk) disable iff (!reset_)
    (lines != 4'b0000) |-> (state == PRESS));
  a_done_not_busy: assert property (@(posedge clk) disable iff (!reset_)
    !(done_q && busy_q));

endmodule

// File: doc/konami_sequencer.md
Name: konami_sequencer

Overview:
- Transmit side of the Konami-code d-pad interface: on command, plays back the 8-step sequence UP, UP, DOWN, DOWN, LEFT, RIGHT, LEFT, RIGHT.
- Each step is a timed press/release on one of four active-high direction lines, directly compatible with the acceptor's release-edge detection.
- Used as an on-board self-test driver and in benches, feeding the acceptor in place of the physical d-pad.
- Can optionally corrupt one chosen step so the acceptor's reject path can be exercised.

Parameters:
PRESS_CYCLES, 4, cycles a direction line is held high per step (legal 1..65535)
GAP_CYCLES, 4, cycles all lines are held low after each release (legal 1..65535)

Ports:
clk  input  1  system clock
reset_  input  1  asynchronous active-low reset
start  input  1  single-cycle request to play the sequence; sampled only in IDLE
abort  input  1  cancels playback; takes effect at the next clock edge
corrupt  input  1  sampled with start; 1 = replace one step with a wrong direction
bad_step  input  3  index 0..7 of the step to corrupt; sampled with start
up  output  1  d-pad up, registered
down  output  1  d-pad down, registered
left  output  1  d-pad left, registered
right  output  1  d-pad right, registered
busy  output  1  high while a sequence is playing
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, reset_ low): state IDLE. All outputs are 0, including up, down, left, right, busy and done. Step index is 0, timer is 0, and latched corrupt/bad_step are 0.
- FSM states:
  - IDLE
  - PRESS
  - GAP
  - DONE
- Step index is 3 bits. The timer is 16 bits and counts down.
- IDLE:
  - If start=1 and abort=0, latch corrupt/bad_step, set index to 0, go to PRESS, and load timer with PRESS_CYCLES-1.
  - start while not in IDLE is ignored (no restart, no queueing).
- PRESS:
  - Exactly one direction output is high: the direction for the current index.
  - Golden table: 0 up, 1 up, 2 down, 3 down, 4 left, 5 right, 6 left, 7 right.
  - If the latched corrupt=1 and index==bad_step, the substitute direction is used instead: up->down, down->left, left->right, right->up.
  - When timer==0, go to GAP and load GAP_CYCLES-1.
  - Otherwise decrement the timer.
- GAP:
  - All direction outputs are 0.
  - When timer==0: if index==7, go to DONE; otherwise increment the index, go to PRESS and load PRESS_CYCLES-1.
  - Otherwise decrement the timer.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Timing with all outputs registered:
  - The first press appears the cycle after start is sampled.
  - Each direction line stays high for exactly PRESS_CYCLES consecutive cycles.
  - Line-low gaps between presses are exactly GAP_CYCLES.
  - busy is high for exactly 8*(PRESS_CYCLES+GAP_CYCLES) cycles, beginning the cycle after start is sampled.
  - done is asserted in the cycle immediately after busy falls.
- Never more than one direction line is high in any cycle. Lines are never high outside PRESS.
- Abort:
  - In PRESS or GAP, abort=1 forces IDLE at the next edge. All direction lines and busy go to 0, and no done pulse is produced.
  - Abort in IDLE or DONE has no effect, except that it blocks a same-cycle start.
  - Simultaneous start and abort in IDLE: abort wins and the sequence does not start.
- Reset mid-sequence: outputs clear asynchronously. After reset_ deasserts the block waits in IDLE for a fresh start.
- corrupt/bad_step changes during playback have no effect; only the values latched at start are used.
- Interval between releases is PRESS_CYCLES+GAP_CYCLES. Integration must keep this below 2^25-1 so the acceptor's inactivity timeout is never hit. With 16-bit parameters this always holds.
- Parameter value 0 is illegal; behaviour for 0 is unspecified.

Test Plan:
- Reset, then start pulse with corrupt=0 (P=4, G=4):
  - Lines are up x4 high / 4 low, up, down, down, left, right, left, right.
  - busy is high for 64 cycles, then done pulses for 1 cycle.
  - A connected acceptor reaches ACCEPT (displays 40 lives).
- start with corrupt=1, bad_step=3:
  - Step 3 drives left instead of down; all other steps match the golden table.
  - done still pulses.
  - The acceptor reaches REJECT (3 lives).
- abort raised during the PRESS of step 4 (left high):
  - On the next edge left=0 and busy=0, and done never pulses.
  - A subsequent start replays from step 0.
- start re-pulsed at cycle 10 and cycle 40 during playback:
  - The output waveform is identical to the single-start run.
  - Exactly one done pulse, at cycle 65.
- start and abort high in the same IDLE cycle:
  - busy stays 0 and no direction line rises for 20 cycles.
- reset_ dropped asynchronously mid-GAP of step 6:
  - All outputs are 0 immediately, before the next clock edge.
  - After release the block stays idle until start, then plays the full 64-cycle sequence.
